// File: rtl/data_bus_controller_if.sv
// Core-side request/response and bus-side control signals of the
// load/store unit. The tristate data bus stays a plain inout on the
// controller so it can be resolved as an ordinary net.
interface data_bus_controller_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_width;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic [1:0]  data_bus_reqw;
    logic        data_bus_reqs;
    logic        stall_lw;

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_width, req_signed, req_addr, req_wdata,
        output stall, resp_valid, load_data, misaligned,
        output data_bus_addr, data_bus_mode, data_bus_reqw, data_bus_reqs, stall_lw
    );

    // Core / environment side.
    modport master (
        output req_valid, req_write, req_width, req_signed, req_addr, req_wdata,
        input  stall, resp_valid, load_data, misaligned,
        input  data_bus_addr, data_bus_mode, data_bus_reqw, data_bus_reqs, stall_lw
    );
endinterface

// File: rtl/data_bus_controller.sv
// Load/store unit between the core memory stage and the shared data bus.
// Takes one request at a time, sequences it onto the bus, stalls the core
// until completion and rejects misaligned accesses without a bus cycle.
module data_bus_controller #(
    parameter int STORE_HOLD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    data_bus_controller_if.slave  bus,
    inout  wire  [31:0]           data_bus_data
);

    localparam int HW = (STORE_HOLD > 1) ? $clog2(STORE_HOLD) : 1;

    typedef enum logic [2:0] {IDLE, LD_ADDR, LD_DATA, ST, DONE} state_t;

    state_t       state_q, state_d;
    logic [31:0]  addr_q, wdata_q, load_data_q;
    logic [1:0]   width_q;
    logic         signed_q, mis_q;
    logic [HW-1:0] hold_q;
    logic         req_bad, drive_bus;

    // Alignment check on the live request; width 11 behaves as a word.
    always_comb begin
        case (bus.req_width)
            2'b01:   req_bad = (bus.req_addr[1:0] == 2'b11);
            2'b10:   req_bad = 1'b0;
            default: req_bad = (bus.req_addr[1:0] != 2'b00);
        endcase
    end

    // Next-state and bus outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        state_d           = state_q;
        bus.stall         = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.misaligned    = 1'b0;
        bus.data_bus_mode = 2'b00;
        bus.data_bus_addr = 32'h0;
        bus.data_bus_reqw = 2'b00;
        bus.data_bus_reqs = 1'b0;
        bus.stall_lw      = 1'b0;
        drive_bus         = 1'b0;
        case (state_q)
            IDLE: begin
                bus.stall = bus.req_valid;
                if (bus.req_valid)
                    state_d = req_bad ? DONE : (bus.req_write ? ST : LD_ADDR);
            end
            LD_ADDR: begin
                bus.stall         = 1'b1;
                bus.stall_lw      = 1'b1;
                bus.data_bus_mode = 2'b01;
                bus.data_bus_addr = addr_q;
                bus.data_bus_reqw = width_q;
                bus.data_bus_reqs = signed_q;
                state_d           = LD_DATA;
            end
            LD_DATA: begin
                bus.stall         = 1'b1;
                bus.data_bus_mode = 2'b01;
                bus.data_bus_addr = addr_q;
                bus.data_bus_reqw = width_q;
                bus.data_bus_reqs = signed_q;
                state_d           = DONE;
            end
            ST: begin
                bus.stall         = 1'b1;
                bus.data_bus_mode = 2'b10;
                bus.data_bus_addr = addr_q;
                bus.data_bus_reqw = width_q;
                bus.data_bus_reqs = signed_q;
                drive_bus         = 1'b1;
                if (hold_q == '0)
                    state_d = DONE;
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                bus.misaligned = mis_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request latch, store hold counter and load capture.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, because load_data must read 0 after reset.
        if (reset) begin
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            width_q     <= 2'b00;
            signed_q    <= 1'b0;
            mis_q       <= 1'b0;
            hold_q      <= '0;
            load_data_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    addr_q   <= bus.req_addr;
                    wdata_q  <= bus.req_wdata;
                    width_q  <= bus.req_width;
                    signed_q <= bus.req_signed;
                    mis_q    <= req_bad;
                    hold_q   <= HW'(STORE_HOLD - 1);
                end
                ST:      if (hold_q != '0) hold_q <= hold_q - HW'(1);
                LD_DATA: load_data_q <= data_bus_data;
                default: ;
            endcase
        end
    end

    assign bus.load_data = load_data_q;

    // The bus is ours only while a store is being held.
    assign data_bus_data = drive_bus ? wdata_q : 32'hz;

endmodule

// File: tb/tb_data_bus_controller.sv
// Self-checking bench for data_bus_controller: directed cases from the
// feature list, then randomized requests against a cycle-count model.
module tb_data_bus_controller;

    localparam int H = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    wire [31:0] data_bus_data;

    data_bus_controller_if ifc();

    data_bus_controller #(.STORE_HOLD(H)) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc),
        .data_bus_data(data_bus_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program memory: stores words little-end-first; the responder byte-swaps
    // and extends, so byte offset 0 is the top byte of the swapped word.
    logic [31:0] mem [16];

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] w, input logic s);
        logic [31:0] word, sw;
        logic [7:0]  b;
        logic [15:0] h;
        int off;
        word = mem[a[5:2]];
        sw   = {word[7:0], word[15:8], word[23:16], word[31:24]};
        off  = int'(a[1:0]);
        b    = 8'(sw >> (24 - 8 * off));
        h    = 16'(sw >> (16 - 8 * ((off > 2) ? 2 : off)));
        case (w)
            2'b10:   return s ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   return s ? {{16{h[15]}}, h} : {16'h0, h};
            default: return sw;
        endcase
    endfunction

    // Responder: samples the address at the edge closing the stall_lw cycle
    // and drives the word for the following cycle.
    logic        rsp_en = 1'b0;
    logic [31:0] rsp_word = 32'h0;
    assign data_bus_data = rsp_en ? rsp_word : 32'hz;

    always @(posedge clk) begin
        rsp_en   <= (ifc.data_bus_mode == 2'b01) && ifc.stall_lw;
        rsp_word <= mem_read(ifc.data_bus_addr, ifc.data_bus_reqw, ifc.data_bus_reqs);
    end

    // Reference model: tracks only "cycles since acceptance" and the total
    // latency of the accepted transaction.
    int          m_k = 0;
    int          m_lat = 1;
    logic        m_load = 1'b0, m_mis = 1'b0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_word = 0, m_ld = 0;
    logic [1:0]  m_w = 0;
    logic        m_s = 0;

    function automatic logic misaligned_rule(input logic [31:0] a, input logic [1:0] w);
        int size;
        size = (w == 2'b01) ? 2 : (w == 2'b10) ? 1 : 4;
        if (size == 4) return (a % 4) != 0;
        if (size == 2) return (a % 4) == 3;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_k  <= 0;
            m_ld <= 32'h0;
        end else if (m_k == 0) begin
            if (ifc.req_valid) begin
                logic mis;
                mis = misaligned_rule(ifc.req_addr, ifc.req_width);
                m_k     <= 1;
                m_mis   <= mis;
                m_load  <= !mis && !ifc.req_write;
                m_lat   <= mis ? 1 : (ifc.req_write ? H + 1 : 3);
                m_addr  <= ifc.req_addr;
                m_wdata <= ifc.req_wdata;
                m_w     <= ifc.req_width;
                m_s     <= ifc.req_signed;
                m_word  <= mem_read(ifc.req_addr, ifc.req_width, ifc.req_signed);
            end
        end else if (m_k == m_lat) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_load && (m_k + 1 == m_lat)) m_ld <= m_word;
        end
    end

    // Compare process: every cycle out of reset, mid-cycle.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            logic e_stall, e_resp, e_mis, e_lw, e_reqs;
            logic [1:0]  e_mode, e_reqw;
            logic [31:0] e_addr;
            e_stall = 0; e_resp = 0; e_mis = 0; e_lw = 0; e_reqs = 0;
            e_mode = 0; e_reqw = 0; e_addr = 0;
            if (m_k == 0) begin
                e_stall = ifc.req_valid;
            end else if (m_k == m_lat) begin
                e_resp = 1'b1;
                e_mis  = m_mis;
            end else begin
                e_stall = 1'b1;
                e_mode  = m_load ? 2'b01 : 2'b10;
                e_lw    = m_load && (m_k == 1);
                e_addr  = m_addr;
                e_reqw  = m_w;
                e_reqs  = m_s;
                if (!m_load) check("bus_wdata", data_bus_data, m_wdata);
            end
            check("stall", ifc.stall, e_stall);
            check("resp_valid", ifc.resp_valid, e_resp);
            check("misaligned", ifc.misaligned, e_mis);
            check("stall_lw", ifc.stall_lw, e_lw);
            check("mode", ifc.data_bus_mode, e_mode);
            check("addr", ifc.data_bus_addr, e_addr);
            check("reqw", ifc.data_bus_reqw, e_reqw);
            check("reqs", ifc.data_bus_reqs, e_reqs);
            check("load_data", ifc.load_data, m_ld);
        end
    end

    // Presents one request (entered at posedge+1 with the controller idle),
    // counts what it sees until resp_valid, then returns in the next cycle.
    task automatic do_req(input logic wr, input logic [1:0] w, input logic s,
                          input logic [31:0] a, input logic [31:0] d, input int gap,
                          output int n_stall, output int n_lw, output int n_wr);
        int n_resp;
        ifc.req_valid  = 1'b1;
        ifc.req_write  = wr;
        ifc.req_width  = w;
        ifc.req_signed = s;
        ifc.req_addr   = a;
        ifc.req_wdata  = d;
        n_stall = 0; n_lw = 0; n_wr = 0; n_resp = 0;
        for (int c = 0; c < 20 && n_resp == 0; c++) begin
            @(negedge clk);
            if (ifc.stall) n_stall++;
            if (ifc.stall_lw) n_lw++;
            if (ifc.data_bus_mode == 2'b10 && data_bus_data == d) n_wr++;
            if (ifc.resp_valid) n_resp++;
        end
        if (n_resp == 0) check("response_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (gap > 0) begin
            ifc.req_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    int ns, nl, nw;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[1] = 32'hEFBEADDE;
        ifc.req_valid = 0; ifc.req_write = 0; ifc.req_width = 0;
        ifc.req_signed = 0; ifc.req_addr = 0; ifc.req_wdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst_resp", ifc.resp_valid, 32'd0);
        check("rst_mode", ifc.data_bus_mode, 32'd0);
        check("rst_load_data", ifc.load_data, 32'd0);
        @(posedge clk); #1;

        // Word load from flash word 1.
        do_req(0, 2'b00, 0, 32'h4, 0, 1, ns, nl, nw);
        check("lw_stall_cycles", ns, 32'd3);
        check("lw_stall_lw_cycles", nl, 32'd1);
        check("lw_data", ifc.load_data, 32'hDEADBEEF);
        do_req(0, 2'b10, 1, 32'h4, 0, 1, ns, nl, nw);
        check("lb_signed", ifc.load_data, 32'hFFFFFFDE);
        do_req(0, 2'b10, 0, 32'h4, 0, 1, ns, nl, nw);
        check("lb_unsigned", ifc.load_data, 32'h000000DE);
        do_req(0, 2'b01, 1, 32'h6, 0, 1, ns, nl, nw);
        check("lh_signed", ifc.load_data, 32'hFFFFBEEF);

        // Store held for H cycles; load_data untouched.
        do_req(1, 2'b00, 0, 32'h3100, 32'h12345678, 1, ns, nl, nw);
        check("sw_stall_cycles", ns, H + 1);
        check("sw_drive_cycles", nw, H);
        check("sw_keeps_load_data", ifc.load_data, 32'hFFFFBEEF);

        // Misaligned word and half-word.
        do_req(0, 2'b00, 0, 32'h2, 0, 1, ns, nl, nw);
        check("mis_w_stall_cycles", ns, 32'd1);
        check("mis_w_stall_lw", nl, 32'd0);
        do_req(0, 2'b01, 0, 32'h3, 0, 1, ns, nl, nw);
        check("mis_h_stall_cycles", ns, 32'd1);
        check("mis_h_keeps_load_data", ifc.load_data, 32'hFFFFBEEF);

        // Back-to-back with req_valid held through DONE; half-word at offset 1.
        do_req(0, 2'b01, 0, 32'h5, 0, 0, ns, nl, nw);
        check("lh_off1", ifc.load_data, 32'h0000ADBE);
        do_req(0, 2'b00, 0, 32'h4, 0, 0, ns, nl, nw);
        check("b2b_stall_cycles", ns, 32'd3);
        check("b2b_data", ifc.load_data, 32'hDEADBEEF);
        ifc.req_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during LD_DATA aborts the load.
        ifc.req_valid = 1'b1; ifc.req_write = 0; ifc.req_width = 2'b00; ifc.req_addr = 32'h4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_abort_mode", ifc.data_bus_mode, 32'd1);
        reset = 1'b1;
        ifc.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_resp", ifc.resp_valid, 32'd0);
        check("abort_stall", ifc.stall, 32'd0);
        check("abort_mode", ifc.data_bus_mode, 32'd0);
        check("abort_addr", ifc.data_bus_addr, 32'd0);
        check("abort_load_data", ifc.load_data, 32'd0);
        @(posedge clk); #1;
        do_req(0, 2'b00, 0, 32'h4, 0, 1, ns, nl, nw);
        check("post_abort_data", ifc.load_data, 32'hDEADBEEF);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 200; i++) begin
            logic        wr;
            logic [31:0] a;
            wr = ($urandom_range(0, 2) == 0);
            a  = wr ? $urandom : 32'($urandom_range(0, 63));
            do_req(wr, 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 2), ns, nl, nw);
        end

        ifc.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
